hex_keypad_scanner: RTL and testbench
=====================================

Name: hex_keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display driver: scans a 4x4 hex matrix keypad, debounces presses and emits 4-bit key codes.
- Shifts each accepted digit into a DW-bit entry register whose output feeds the display driver's data input.
- Drives keypad columns as time-multiplexed active-low strobes, the way the display driver strobes anodes.

Parameters:
- DW, 32, entry register width; multiple of 4, >= 8.
- SCAN_DIV, 50000, clk cycles each column is driven; >= 4.
- DEBOUNCE_CNT, 500000, consecutive stable cycles required for press and for release; >= 2.
- REPEAT_CNT, 25000000, auto-repeat period in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst_i  input  1  asynchronous active-low reset.
- row_i  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- clr_i  input  1  synchronous clear of data_o and digit_cnt_o.
- col_o  output  4  column strobes, active-low, one-hot-low.
- key_valid_o  output  1  one-cycle pulse per accepted key.
- key_code_o  output  4  code of last accepted key.
- data_o  output  DW  digit entry register.
- digit_cnt_o  output  $clog2(DW/4)+1  digits entered, saturating at DW/4.

Behaviour:
- Reset (rst_i=0, async): col_o=4'b1110, key_valid_o=0, key_code_o=0, data_o=0, digit_cnt_o=0, FSM=SCAN, all counters 0.
- Synchronise row_i with two flops before use (rows_s); raw row_i is used nowhere else.
- Key code = {row_idx[1:0], col_idx[1:0]}; row 0 = row_i[0], column 0 = col_o[0] low.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - Hold the current column low for SCAN_DIV cycles.
  - On the last dwell cycle, sample rows_s.
  - Exactly one row low: latch row_idx/col_idx and the pattern, freeze col_o, go DEBOUNCE.
  - Otherwise advance the column 0->1->2->3->0 (wrap) and restart dwell. Zero or more than one row low counts as no key.
- DEBOUNCE:
  - Count cycles where rows_s equals the latched pattern.
  - Any mismatch: clear counter, resume SCAN at the next column.
  - Count reaches DEBOUNCE_CNT-1 with match: on the next edge pulse key_valid_o for one cycle, update key_code_o, shift data_o <= {data_o[DW-5:0], code}, increment digit_cnt_o (saturating), go HELD.
  - Oldest digit falls off the MSB end.
- HELD: column stays frozen. rows_s==4'hF starts RELEASE; any other pattern (second key added) stays in HELD with no new event.
- RELEASE:
  - Count consecutive cycles with rows_s==4'hF.
  - Any row low: back to HELD, counter cleared.
  - Count reaches DEBOUNCE_CNT-1: go SCAN at column 0.
- clr_i=1: data_o and digit_cnt_o go to 0 next edge. FSM is unaffected.
- clr_i coincident with an accept edge: clear wins, and the accepted code is not written. key_valid_o and key_code_o still update.
- key_valid_o is never asserted in consecutive cycles.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD, with the latched pattern still matching, a repeat counter runs. Every REPEAT_CNT cycles it re-pulses key_valid_o and shifts the same code again.
  - Counter clears on entry to HELD and on any mismatch.
- Undefined: repeat logic is absent. Exactly one event per press.

Test Plan (SCAN_DIV=8, DEBOUNCE_CNT=16, REPEAT_CNT=64, DW=32):
- Reset mid-scan, then hold rst_i low -> col_o=4'b1110, data_o=0, key_valid_o=0 immediately (async), with no clk edge needed.
- Press row 2 while column 1 strobed, held 100 cycles, then released -> exactly one key_valid_o pulse, key_code_o=4'h9, data_o=32'h9, digit_cnt_o=1.
- Press row 0 for 10 cycles only (bounce) -> no key_valid_o, scanning resumes, data_o unchanged.
- Enter nine keys 1..9 -> data_o=32'h23456789, digit_cnt_o=8 (saturated).
- Rows 0 and 1 pulled low together -> ignored, no pulse. Assert clr_i on the accept cycle of a valid key -> data_o=0, key_code_o updated.
- KEYPAD_AUTOREPEAT_EN defined, key F held 300 cycles -> first pulse, then one repeat pulse every 64 cycles, data_o low nibbles all F. Undefined -> single pulse.

Source files
------------

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner
//   Scans a 4x4 hex matrix keypad by strobing columns low one at a time,
//   debounces press and release, and emits a 4-bit key code per accepted
//   key. Each accepted digit is shifted into a DW-bit entry register.
//
// Ports
//   clk          system clock
//   rst_i        asynchronous active-low reset
//   row_i[3:0]   keypad rows, active-low, asynchronous to clk
//   clr_i        synchronous clear of data_o and digit_cnt_o
//   col_o[3:0]   column strobes, active-low, one-hot-low
//   key_valid_o  one-cycle pulse per accepted key
//   key_code_o   {row_idx, col_idx} of the last accepted key
//   data_o       digit entry register, newest digit in the low nibble
//   digit_cnt_o  digits entered, saturating at DW/4
//
// Build option
//   KEYPAD_AUTOREPEAT_EN  when defined, a held key re-fires every REPEAT_CNT
//                         cycles; otherwise exactly one event per press.

module hex_keypad_scanner #(
   parameter int unsigned DW           = 32,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned DEBOUNCE_CNT = 500000,
   parameter int unsigned REPEAT_CNT   = 25000000
) (
   input  logic                     clk,
   input  logic                     rst_i,
   input  logic [3:0]               row_i,
   input  logic                     clr_i,
   output logic [3:0]               col_o,
   output logic                     key_valid_o,
   output logic [3:0]               key_code_o,
   output logic [DW-1:0]            data_o,
   output logic [$clog2(DW/4):0]    digit_cnt_o
);

   localparam int unsigned SW  = $clog2(SCAN_DIV);
   localparam int unsigned DBW = $clog2(DEBOUNCE_CNT);
   localparam int unsigned CW  = $clog2(DW/4) + 1;

   if ((DW % 4 != 0) || (DW < 8) || (SCAN_DIV < 4) || (DEBOUNCE_CNT < 2) ||
       (REPEAT_CNT < 2)) begin : g_bad_cfg
      $error("hex_keypad_scanner: illegal parameter set");
   end

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      rows_meta_q, rows_s_q;
   logic [1:0]      col_idx_q, col_idx_d;
   logic [1:0]      row_idx_q, row_idx_d;
   logic [3:0]      pat_q, pat_d;
   logic [SW-1:0]   dwell_q, dwell_d;
   logic [DBW-1:0]  cnt_q, cnt_d;
   logic            key_valid_q;
   logic [3:0]      key_code_q;
   logic [DW-1:0]   data_q;
   logic [CW-1:0]   digit_cnt_q;
   logic            accept;
   logic            repeat_fire;
   logic            key_evt;
   logic            one_low;
   logic [1:0]      hit_row;
   logic [3:0]      code;

   // Rows idle high through the synchroniser so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         rows_meta_q <= 4'hF;
         rows_s_q    <= 4'hF;
      end else begin
         rows_meta_q <= row_i;
         rows_s_q    <= rows_meta_q;
      end
   end

   // Exactly one row low is a key; none or several is treated as no key.
   always_comb begin
      one_low = 1'b1;
      hit_row = 2'd0;
      case (rows_s_q)
         4'b1110: hit_row = 2'd0;
         4'b1101: hit_row = 2'd1;
         4'b1011: hit_row = 2'd2;
         4'b0111: hit_row = 2'd3;
         default: one_low = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      col_idx_d = col_idx_q;
      row_idx_d = row_idx_q;
      pat_d     = pat_q;
      dwell_d   = dwell_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      case (state_q)
         ST_SCAN: begin
            if (dwell_q == SW'(SCAN_DIV - 1)) begin
               dwell_d = '0;
               if (one_low) begin
                  row_idx_d = hit_row;
                  pat_d     = rows_s_q;
                  cnt_d     = '0;
                  state_d   = ST_DEBOUNCE;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end else begin
               dwell_d = dwell_q + SW'(1);
            end
         end
         ST_DEBOUNCE: begin
            if (rows_s_q == pat_q) begin
               if (cnt_q == DBW'(DEBOUNCE_CNT - 1)) begin
                  cnt_d   = '0;
                  accept  = 1'b1;
                  state_d = ST_HELD;
               end else begin
                  cnt_d = cnt_q + DBW'(1);
               end
            end else begin
               cnt_d     = '0;
               dwell_d   = '0;
               col_idx_d = col_idx_q + 2'd1;
               state_d   = ST_SCAN;
            end
         end
         ST_HELD: begin
            if (rows_s_q == 4'hF) begin
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (rows_s_q == 4'hF) begin
               if (cnt_q == DBW'(DEBOUNCE_CNT - 1)) begin
                  cnt_d     = '0;
                  dwell_d   = '0;
                  col_idx_d = 2'd0;
                  state_d   = ST_SCAN;
               end else begin
                  cnt_d = cnt_q + DBW'(1);
               end
            end else begin
               cnt_d   = '0;
               state_d = ST_HELD;
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= ST_SCAN;
         col_idx_q <= 2'd0;
         row_idx_q <= 2'd0;
         pat_q     <= 4'hF;
         dwell_q   <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         col_idx_q <= col_idx_d;
         row_idx_q <= row_idx_d;
         pat_q     <= pat_d;
         dwell_q   <= dwell_d;
         cnt_q     <= cnt_d;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_CNT);
   logic [RW-1:0] rep_q, rep_d;

   // Counter idles at zero outside HELD, so entry to HELD starts it from zero.
   always_comb begin
      rep_d       = '0;
      repeat_fire = 1'b0;
      if ((state_q == ST_HELD) && (rows_s_q == pat_q)) begin
         if (rep_q == RW'(REPEAT_CNT - 1)) begin
            repeat_fire = 1'b1;
         end else begin
            rep_d = rep_q + RW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end
`else
   assign repeat_fire = 1'b0;
`endif

   assign key_evt = accept | repeat_fire;
   assign code    = {row_idx_q, col_idx_q};

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         data_q      <= '0;
         digit_cnt_q <= '0;
      end else begin
         key_valid_q <= key_evt;
         if (key_evt) begin
            key_code_q <= code;
         end
         // Clear beats a coincident accept; the key event itself still fires.
         if (clr_i) begin
            data_q      <= '0;
            digit_cnt_q <= '0;
         end else if (key_evt) begin
            data_q <= {data_q[DW-5:0], code};
            if (digit_cnt_q != CW'(DW/4)) begin
               digit_cnt_q <= digit_cnt_q + CW'(1);
            end
         end
      end
   end

   always_comb begin
      case (col_idx_q)
         2'd0:    col_o = 4'b1110;
         2'd1:    col_o = 4'b1101;
         2'd2:    col_o = 4'b1011;
         default: col_o = 4'b0111;
      endcase
   end

   assign key_valid_o = key_valid_q;
   assign key_code_o  = key_code_q;
   assign data_o      = data_q;
   assign digit_cnt_o = digit_cnt_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner with a 4x4 switch-matrix model.
module tb_hex_keypad_scanner;

   localparam int unsigned DW = 32;

   logic          clk   = 1'b0;
   logic          rst_i = 1'b0;
   logic          clr_i = 1'b0;
   logic [3:0]    row_i;
   logic [3:0]    col_o;
   logic          key_valid_o;
   logic [3:0]    key_code_o;
   logic [DW-1:0] data_o;
   logic [3:0]    digit_cnt_o;
   logic [15:0]   keys = '0;   // bit r*4+c closes row r to column c

   int total = 0;
   int bad   = 0;

   // pulse monitor
   int            cyc = 0;
   int            pulses = 0;
   int            consec = 0;
   logic          prev_valid = 1'b0;
   logic [DW-1:0] pulse_data = '0;
   logic [3:0]    pulse_dcnt = '0;
   bit            gap_win = 1'b0;
   int            gap_last = -1;
   int            gap_min = 0;
   int            gap_max = 0;

   always #5 clk = ~clk;

   hex_keypad_scanner #(
      .DW(32), .SCAN_DIV(8), .DEBOUNCE_CNT(16), .REPEAT_CNT(64)
   ) dut (
      .clk(clk), .rst_i(rst_i), .row_i(row_i), .clr_i(clr_i),
      .col_o(col_o), .key_valid_o(key_valid_o), .key_code_o(key_code_o),
      .data_o(data_o), .digit_cnt_o(digit_cnt_o)
   );

   always_comb begin
      row_i = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (key_valid_o === 1'b1) begin
         if (prev_valid) consec = consec + 1;
         if (gap_win) begin
            if (gap_last >= 0) begin
               if (cyc - gap_last < gap_min) gap_min = cyc - gap_last;
               if (cyc - gap_last > gap_max) gap_max = cyc - gap_last;
            end
            gap_last = cyc;
         end
         pulses     = pulses + 1;
         pulse_data = data_o;
         pulse_dcnt = digit_cnt_o;
      end
      prev_valid = (key_valid_o === 1'b1);
   end

   task automatic press(input int r, input int c, input int hold);
      keys[r*4+c] = 1'b1;
      repeat (hold) @(negedge clk);
      keys = '0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_i = 1'b1;
      repeat (20) @(negedge clk);
      total++; if (col_o !== 4'b1011) begin bad++; $display("FAIL scan_col: got %b expected 1011", col_o); end
      #2 rst_i = 1'b0;
      #1;
      total++; if (col_o !== 4'b1110) begin bad++; $display("FAIL rst_col: got %b expected 1110", col_o); end
      total++; if (data_o !== '0) begin bad++; $display("FAIL rst_data: got %h expected 0", data_o); end
      total++; if (key_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", key_valid_o); end
      total++; if (key_code_o !== 4'h0) begin bad++; $display("FAIL rst_code: got %h expected 0", key_code_o); end
      total++; if (digit_cnt_o !== 4'd0) begin bad++; $display("FAIL rst_cnt: got %0d expected 0", digit_cnt_o); end
      repeat (3) @(negedge clk);
      total++; if (col_o !== 4'b1110) begin bad++; $display("FAIL rst_hold_col: got %b expected 1110", col_o); end
      rst_i = 1'b1;
   endtask

   task automatic test_single_press();
      int p0;
      p0 = pulses;
      press(2, 1, 100);
      total++; if (pulses - p0 != 1) begin bad++; $display("FAIL press_pulses: got %0d expected 1", pulses - p0); end
      total++; if (key_code_o !== 4'h9) begin bad++; $display("FAIL press_code: got %h expected 9", key_code_o); end
      total++; if (data_o !== 32'h9) begin bad++; $display("FAIL press_data: got %h expected 9", data_o); end
      total++; if (pulse_data !== 32'h9) begin bad++; $display("FAIL press_data_at_pulse: got %h expected 9", pulse_data); end
      total++; if (digit_cnt_o !== 4'd1) begin bad++; $display("FAIL press_cnt: got %0d expected 1", digit_cnt_o); end
   endtask

   task automatic test_bounce();
      int   p0;
      bit   found;
      logic [3:0] seen;
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (col_o === 4'b1110) found = 1'b1;
      end
      total++; if (!found) begin bad++; $display("FAIL bounce_wait_col0: got timeout expected col 1110"); end
      p0 = pulses;
      keys[0] = 1'b1;
      repeat (10) @(negedge clk);
      keys = '0;
      repeat (40) @(negedge clk);
      total++; if (pulses - p0 != 0) begin bad++; $display("FAIL bounce_pulses: got %0d expected 0", pulses - p0); end
      total++; if (data_o !== 32'h9) begin bad++; $display("FAIL bounce_data: got %h expected 9", data_o); end
      seen = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         seen = seen | ~col_o;
      end
      total++; if (seen !== 4'hF) begin bad++; $display("FAIL bounce_rescan: got %b expected 1111", seen); end
   endtask

   task automatic test_nine_keys();
      int p0;
      p0 = pulses;
      for (int k = 1; k <= 9; k++) press(k / 4, k % 4, 100);
      total++; if (pulses - p0 != 9) begin bad++; $display("FAIL nine_pulses: got %0d expected 9", pulses - p0); end
      total++; if (data_o !== 32'h23456789) begin bad++; $display("FAIL nine_data: got %h expected 23456789", data_o); end
      total++; if (digit_cnt_o !== 4'd8) begin bad++; $display("FAIL nine_cnt: got %0d expected 8", digit_cnt_o); end
      total++; if (key_code_o !== 4'h9) begin bad++; $display("FAIL nine_code: got %h expected 9", key_code_o); end
   endtask

   task automatic test_clear();
      @(negedge clk); clr_i = 1'b1;
      @(negedge clk); clr_i = 1'b0;
      total++; if (data_o !== '0) begin bad++; $display("FAIL clr_data: got %h expected 0", data_o); end
      total++; if (digit_cnt_o !== 4'd0) begin bad++; $display("FAIL clr_cnt: got %0d expected 0", digit_cnt_o); end
      press(2, 2, 100);
      total++; if (data_o !== 32'hA) begin bad++; $display("FAIL after_clr_data: got %h expected a", data_o); end
      total++; if (digit_cnt_o !== 4'd1) begin bad++; $display("FAIL after_clr_cnt: got %0d expected 1", digit_cnt_o); end
   endtask

   task automatic test_two_rows();
      int p0;
      p0 = pulses;
      keys[0] = 1'b1;
      keys[4] = 1'b1;
      repeat (100) @(negedge clk);
      keys = '0;
      repeat (40) @(negedge clk);
      total++; if (pulses - p0 != 0) begin bad++; $display("FAIL two_rows_pulses: got %0d expected 0", pulses - p0); end
      total++; if (data_o !== 32'hA) begin bad++; $display("FAIL two_rows_data: got %h expected a", data_o); end
   endtask

   task automatic test_clr_on_accept();
      int p0;
      p0 = pulses;
      clr_i = 1'b1;
      press(1, 1, 100);
      clr_i = 1'b0;
      total++; if (pulses - p0 != 1) begin bad++; $display("FAIL clracc_pulses: got %0d expected 1", pulses - p0); end
      total++; if (pulse_data !== '0) begin bad++; $display("FAIL clracc_data_at_pulse: got %h expected 0", pulse_data); end
      total++; if (pulse_dcnt !== 4'd0) begin bad++; $display("FAIL clracc_cnt_at_pulse: got %0d expected 0", pulse_dcnt); end
      total++; if (key_code_o !== 4'h5) begin bad++; $display("FAIL clracc_code: got %h expected 5", key_code_o); end
      total++; if (data_o !== '0) begin bad++; $display("FAIL clracc_data: got %h expected 0", data_o); end
   endtask

   task automatic test_autorepeat();
      int p0;
      p0       = pulses;
      gap_win  = 1'b1;
      gap_last = -1;
      gap_min  = 1000;
      gap_max  = 0;
      press(3, 3, 300);
      gap_win  = 1'b0;
      total++; if (key_code_o !== 4'hF) begin bad++; $display("FAIL rep_code: got %h expected f", key_code_o); end
`ifdef KEYPAD_AUTOREPEAT_EN
      total++; if (pulses - p0 < 4 || pulses - p0 > 5) begin bad++; $display("FAIL rep_pulses: got %0d expected 4..5", pulses - p0); end
      total++; if (gap_min != 64 || gap_max != 64) begin bad++; $display("FAIL rep_gap: got %0d..%0d expected 64", gap_min, gap_max); end
      total++; if (data_o[15:0] !== 16'hFFFF) begin bad++; $display("FAIL rep_data: got %h expected ffff in low half", data_o); end
`else
      total++; if (pulses - p0 != 1) begin bad++; $display("FAIL rep_pulses: got %0d expected 1", pulses - p0); end
      total++; if (data_o !== 32'hF) begin bad++; $display("FAIL rep_data: got %h expected f", data_o); end
`endif
   endtask

   task automatic test_async_reset_data();
      @(negedge clk);
      #2 rst_i = 1'b0;
      #1;
      total++; if (data_o !== '0) begin bad++; $display("FAIL arst_data: got %h expected 0", data_o); end
      total++; if (digit_cnt_o !== 4'd0) begin bad++; $display("FAIL arst_cnt: got %0d expected 0", digit_cnt_o); end
      total++; if (key_code_o !== 4'h0) begin bad++; $display("FAIL arst_code: got %h expected 0", key_code_o); end
      total++; if (col_o !== 4'b1110) begin bad++; $display("FAIL arst_col: got %b expected 1110", col_o); end
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_nine_keys();
      test_clear();
      test_two_rows();
      test_clr_on_accept();
      test_autorepeat();
      test_async_reset_data();
      total++; if (consec != 0) begin bad++; $display("FAIL consecutive_pulses: got %0d expected 0", consec); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
